// File: rtl/serial_code_converter.sv
// rtl/serial_code_converter.sv - serial LSB-first BCD<->XS3 digit converter with framing and validation
// Mealy datapath: z, digit_done, frame_done and err follow x/en in the same cycle.
module serial_code_converter #(
    parameter  int DIGITS = 2,
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          mode,
    input  logic          x,
    output logic          z,
    output logic          z_valid,
    output logic          digit_done,
    output logic          frame_done,
    output logic          err,
    output logic          frame_err,
    output logic [CW-1:0] digit_cnt
);

    logic [1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] digit_cnt_q, digit_cnt_d;
    logic          cb_q, cb_d;
    logic [2:0]    sr_q, sr_d;
    logic          mode_q, mode_d;
    logic          frame_err_q, frame_err_d;

    logic          first_bit;
    logic          last_bit;
    logic          last_digit;
    logic          m;
    logic          k;
    logic          c;
    logic          cb_next;
    logic [3:0]    v;
    logic          bad;

    always_comb begin
        first_bit  = (bit_cnt_q == 2'd0) && (digit_cnt_q == '0);
        last_bit   = (bit_cnt_q == 2'd3);
        last_digit = (digit_cnt_q == CW'(DIGITS - 1));
        // Mode is latched on the first bit of a frame so mid-frame changes are ignored.
        m          = first_bit ? mode : mode_q;
        // Constant 3 = 4'b0011 presented LSB first.
        k          = ~bit_cnt_q[1];
        c          = (bit_cnt_q == 2'd0) ? 1'b0 : cb_q;
        if (m) begin
            cb_next = (~x & (k | c)) | (k & c);
        end else begin
            cb_next = (x & k) | (x & c) | (k & c);
        end
        v = {x, sr_q};
        if (m) begin
            bad = (v < 4'd3) || (v > 4'd12);
        end else begin
            bad = (v > 4'd9);
        end
    end

    always_comb begin
        z          = en & (x ^ k ^ c);
        z_valid    = en;
        digit_done = en & last_bit;
        frame_done = en & last_bit & last_digit;
        err        = en & last_bit & bad;
        frame_err  = frame_err_q;
        digit_cnt  = digit_cnt_q;
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        digit_cnt_d = digit_cnt_q;
        cb_d        = cb_q;
        sr_d        = sr_q;
        mode_d      = mode_q;
        frame_err_d = frame_err_q;
        if (en) begin
            bit_cnt_d = bit_cnt_q + 2'd1;
            cb_d      = cb_next;
            case (bit_cnt_q)
                2'd0:    sr_d[0] = x;
                2'd1:    sr_d[1] = x;
                2'd2:    sr_d[2] = x;
                default: sr_d    = sr_q;
            endcase
            if (last_bit) begin
                digit_cnt_d = last_digit ? '0 : digit_cnt_q + CW'(1);
            end
            if (first_bit) begin
                mode_d = mode;
            end
            // The flag is sticky for the whole frame; a new frame's first bit clears it.
            if (err) begin
                frame_err_d = 1'b1;
            end else if (first_bit) begin
                frame_err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt_q   <= 2'd0;
            digit_cnt_q <= '0;
            cb_q        <= 1'b0;
            sr_q        <= 3'd0;
            mode_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            digit_cnt_q <= digit_cnt_d;
            cb_q        <= cb_d;
            sr_q        <= sr_d;
            mode_q      <= mode_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_serial_code_converter.sv
// tb/tb_serial_code_converter.sv - scoreboard bench for serial_code_converter
// Expected per-bit records come from whole-digit arithmetic (d+3 / d-3 mod 16).
module tb_serial_code_converter;

    localparam int DIGITS = 2;
    localparam int CW     = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          en    = 1'b0;
    logic          mode  = 1'b0;
    logic          x     = 1'b0;
    logic          z, z_valid, digit_done, frame_done, err, frame_err;
    logic [CW-1:0] digit_cnt;

    serial_code_converter #(.DIGITS(DIGITS)) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .x          (x),
        .z          (z),
        .z_valid    (z_valid),
        .digit_done (digit_done),
        .frame_done (frame_done),
        .err        (err),
        .frame_err  (frame_err),
        .digit_cnt  (digit_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          z;
        logic          dd;
        logic          fd;
        logic          er;
        logic          fe;
        logic [CW-1:0] dc;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    int   didx  = 0;
    logic fmode = 1'b0;
    logic flag  = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive_cycle(input logic e, input logic xb, input logic mb);
        @(posedge clock);
        #1;
        en   = e;
        x    = xb;
        mode = mb;
    endtask

    // Drives nb bits (LSB first) of digit d; stall idle cycles are inserted after bit 1.
    task automatic drive_digit(input int d, input logic m_req, input int stall, input bit flip, input int nb);
        logic [3:0] out;
        logic [3:0] din;
        logic       bad;
        logic       first;
        logic       mb;
        exp_t       e;
        if (didx == 0) fmode = m_req;
        din = 4'(d);
        out = fmode ? 4'(d + 13) : 4'(d + 3);
        bad = fmode ? (d < 3 || d > 12) : (d > 9);
        for (int i = 0; i < nb; i++) begin
            first = (didx == 0) && (i == 0);
            if (first)     mb = fmode;
            else if (flip) mb = ~fmode;
            else           mb = 1'($urandom_range(0, 1));
            drive_cycle(1'b1, din[i], mb);
            e.z  = out[i];
            e.dd = (i == 3);
            e.fd = (i == 3) && (didx == DIGITS - 1);
            e.er = (i == 3) && bad;
            e.fe = flag;
            e.dc = CW'(didx);
            q.push_back(e);
            if (first) flag = 1'b0;
            if (i == 3 && bad) flag = 1'b1;
            if (i == 1) begin
                for (int s = 0; s < stall; s++)
                    drive_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        if (nb == 4) didx = (didx + 1) % DIGITS;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            check("z_valid", {15'd0, z_valid}, {15'd0, en});
            if (z_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 16'd1, 16'd0);
                end else begin
                    e = q.pop_front();
                    check("bit_outputs", {10'd0, frame_err, err, frame_done, digit_done, z, digit_cnt},
                          {10'd0, e.fe, e.er, e.fd, e.dd, e.z, e.dc});
                end
            end else begin
                check("idle_outputs", {12'd0, z, digit_done, frame_done, err}, 16'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d left expected 0", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_state", {10'd0, z, z_valid, digit_done, frame_done, err, frame_err, digit_cnt}, 16'd0);
        @(negedge clock);
        reset = 1'b0;

        drive_digit(5, 1'b0, 0, 1'b0, 4);
        drive_digit(0, 1'b0, 0, 1'b0, 4);
        drive_digit(8, 1'b1, 0, 1'b1, 4);
        drive_digit(8, 1'b1, 0, 1'b1, 4);
        drive_digit(10, 1'b0, 0, 1'b0, 4);
        drive_digit(0, 1'b0, 0, 1'b0, 4);
        drive_digit(1, 1'b0, 0, 1'b0, 4);
        drive_digit(2, 1'b0, 0, 1'b0, 4);
        drive_digit(9, 1'b0, 0, 1'b0, 4);
        drive_digit(0, 1'b0, 0, 1'b0, 4);
        drive_digit(5, 1'b0, 3, 1'b0, 4);
        drive_digit(0, 1'b0, 0, 1'b0, 4);

        // Invalid digit 0 makes frame_err high, then reset during digit 1.
        drive_digit(12, 1'b0, 0, 1'b0, 4);
        drive_digit(7, 1'b0, 0, 1'b0, 3);
        @(posedge clock);
        #1;
        en    = 1'b0;
        reset = 1'b1;
        #1;
        check("async_reset", {13'd0, frame_err, digit_cnt, z}, 16'd0);
        didx = 0;
        flag = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        drive_digit(0, 1'b0, 0, 1'b0, 4);
        drive_digit(4, 1'b0, 0, 1'b0, 4);

        for (int n = 0; n < 80; n++) begin
            drive_digit(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b0, 4);
        end

        drive_cycle(1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        check("queue_drained", 16'(q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
